// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register enable/flush control for the VLIW core: load-use stalls,
// taken-branch squash and a full freeze while data memory is busy.
module pipe_hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT       = 16,
    parameter int unsigned STAT_W            = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [2:0]        id_Rm,
    input  logic [2:0]        id_Rn,
    input  logic [2:0]        id_Sm,
    input  logic [2:0]        id_Sn,
    input  logic              id_use_Rm,
    input  logic              id_use_Rn,
    input  logic              id_use_Sm,
    input  logic              id_use_Sn,
    input  logic              ex_memRead,
    input  logic              ex_R_regWrite,
    input  logic              ex_S_regWrite,
    input  logic [2:0]        ex_Rd,
    input  logic [2:0]        ex_Sd,
    input  logic              mem_branch,
    input  logic              mem_taken,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_write,
    output logic              ex_mem_write,
    output logic              mem_wb_write,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] flush_events,
    output logic              mem_timeout
);

    localparam int unsigned LCNT_W = $clog2(LOAD_STALL_CYCLES + 1);
    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        MWAIT  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    state_e              ret_q, ret_d;
    state_e              eff_state;
    logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [STAT_W-1:0]   stall_q, stall_d;
    logic [STAT_W-1:0]   flush_q, flush_d;
    logic                tmo_q, tmo_d;
    logic                r_hit, s_hit, haz, br;

    assign r_hit = ex_R_regWrite & ((id_use_Rm & (id_Rm == ex_Rd)) |
                                    (id_use_Rn & (id_Rn == ex_Rd)));
    assign s_hit = ex_S_regWrite & ((id_use_Sm & (id_Sm == ex_Sd)) |
                                    (id_use_Sn & (id_Sn == ex_Sd)));
    assign haz   = id_valid & ex_memRead & (r_hit | s_hit);
    assign br    = mem_branch & mem_taken;

    // Once memory is ready again, MWAIT behaves as the state it interrupted
    assign eff_state = (state_q == MWAIT) ? ret_q : state_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
            ret_q   <= RUN;
            lcnt_q  <= '0;
            wcnt_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            lcnt_q  <= lcnt_d;
            wcnt_q  <= wcnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        lcnt_d  = lcnt_q;
        wcnt_d  = wcnt_q;
        flush_d = flush_q;
        tmo_d   = tmo_q;
        stall_d = (!pc_write && (stall_q != STAT_MAX)) ? stall_q + STAT_W'(1) : stall_q;

        if (mem_busy) begin
            if (state_q != MWAIT) begin
                ret_d   = state_q;
                state_d = MWAIT;
                wcnt_d  = WCNT_W'(1);
                tmo_d   = tmo_q | (MEM_TIMEOUT == 1);
            end else begin
                if (wcnt_q != WCNT_W'(MEM_TIMEOUT)) begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
                if ((wcnt_q + WCNT_W'(1)) == WCNT_W'(MEM_TIMEOUT)) begin
                    tmo_d = 1'b1;
                end
            end
        end else begin
            wcnt_d = '0;
            if (br) begin
                state_d = RUN;
                lcnt_d  = '0;
                if (flush_q != STAT_MAX) begin
                    flush_d = flush_q + STAT_W'(1);
                end
            end else if (eff_state == LSTALL) begin
                lcnt_d  = lcnt_q - LCNT_W'(1);
                state_d = (lcnt_q == LCNT_W'(1)) ? RUN : LSTALL;
            end else if (haz && (LOAD_STALL_CYCLES > 1)) begin
                state_d = LSTALL;
                lcnt_d  = LCNT_W'(LOAD_STALL_CYCLES - 1);
            end else begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;

        if (reset && !mem_busy) begin
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            mem_wb_write = 1'b1;
            if (br) begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if ((eff_state == LSTALL) || haz) begin
                id_ex_flush = 1'b1;
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
    assign mem_timeout  = tmo_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against
// a countdown-based model; a second instance with 4-bit statistics checks saturation.
module tb_pipe_hazard_ctrl;

    localparam int LSC = 2;
    localparam int MT  = 16;

    localparam logic [7:0] CTL_ZERO  = 8'b00000_000;
    localparam logic [7:0] CTL_NORM  = 8'b11111_000;
    localparam logic [7:0] CTL_STALL = 8'b00111_010;
    localparam logic [7:0] CTL_BR    = 8'b11111_111;

    logic clk = 1'b0;
    logic reset;
    logic id_valid;
    logic [2:0] id_Rm, id_Rn, id_Sm, id_Sn;
    logic id_use_Rm, id_use_Rn, id_use_Sm, id_use_Sn;
    logic ex_memRead, ex_R_regWrite, ex_S_regWrite;
    logic [2:0] ex_Rd, ex_Sd;
    logic mem_branch, mem_taken, mem_busy;

    logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic if_id_flush, id_ex_flush, ex_mem_flush;
    logic [15:0] stall_cycles, flush_events;
    logic mem_timeout;

    logic d4_pc_write, d4_if_id_write, d4_id_ex_write, d4_ex_mem_write, d4_mem_wb_write;
    logic d4_if_id_flush, d4_id_ex_flush, d4_ex_mem_flush;
    logic [3:0] d4_stall_cycles, d4_flush_events;
    logic d4_mem_timeout;

    int total = 0;
    int bad   = 0;

    int m_stall_left, m_busy_run, m_stalls, m_flushes;
    bit m_tmo;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_Rm(id_Rm), .id_Rn(id_Rn), .id_Sm(id_Sm), .id_Sn(id_Sn),
        .id_use_Rm(id_use_Rm), .id_use_Rn(id_use_Rn), .id_use_Sm(id_use_Sm), .id_use_Sn(id_use_Sn),
        .ex_memRead(ex_memRead), .ex_R_regWrite(ex_R_regWrite), .ex_S_regWrite(ex_S_regWrite),
        .ex_Rd(ex_Rd), .ex_Sd(ex_Sd), .mem_branch(mem_branch), .mem_taken(mem_taken),
        .mem_busy(mem_busy), .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .stall_cycles(stall_cycles), .flush_events(flush_events), .mem_timeout(mem_timeout)
    );

    pipe_hazard_ctrl #(.STAT_W(4)) dut4 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_Rm(id_Rm), .id_Rn(id_Rn), .id_Sm(id_Sm), .id_Sn(id_Sn),
        .id_use_Rm(id_use_Rm), .id_use_Rn(id_use_Rn), .id_use_Sm(id_use_Sm), .id_use_Sn(id_use_Sn),
        .ex_memRead(ex_memRead), .ex_R_regWrite(ex_R_regWrite), .ex_S_regWrite(ex_S_regWrite),
        .ex_Rd(ex_Rd), .ex_Sd(ex_Sd), .mem_branch(mem_branch), .mem_taken(mem_taken),
        .mem_busy(mem_busy), .pc_write(d4_pc_write), .if_id_write(d4_if_id_write),
        .id_ex_write(d4_id_ex_write), .ex_mem_write(d4_ex_mem_write), .mem_wb_write(d4_mem_wb_write),
        .if_id_flush(d4_if_id_flush), .id_ex_flush(d4_id_ex_flush), .ex_mem_flush(d4_ex_mem_flush),
        .stall_cycles(d4_stall_cycles), .flush_events(d4_flush_events), .mem_timeout(d4_mem_timeout)
    );

    function automatic logic [7:0] ctl();
        return {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                if_id_flush, id_ex_flush, ex_mem_flush};
    endfunction

    function automatic logic [7:0] ctl4();
        return {d4_pc_write, d4_if_id_write, d4_id_ex_write, d4_ex_mem_write, d4_mem_wb_write,
                d4_if_id_flush, d4_id_ex_flush, d4_ex_mem_flush};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_Rm = 0; id_Rn = 0; id_Sm = 0; id_Sn = 0;
        id_use_Rm = 0; id_use_Rn = 0; id_use_Sm = 0; id_use_Sn = 0;
        ex_memRead = 0; ex_R_regWrite = 0; ex_S_regWrite = 0; ex_Rd = 0; ex_Sd = 0;
        mem_branch = 0; mem_taken = 0; mem_busy = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        tick();
        tick();
        reset = 1;
    endtask

    task automatic set_r_hazard();
        id_valid = 1; id_use_Rm = 1; id_Rm = 3'd3;
        ex_memRead = 1; ex_R_regWrite = 1; ex_Rd = 3'd3;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (ctl() !== CTL_ZERO) begin
                bad++; $display("FAIL reset_ctl cyc%0d: got %b want %b", i, ctl(), CTL_ZERO);
            end
            tick();
        end
        reset = 1;
        #1;
        total++;
        if (ctl() !== CTL_NORM) begin
            bad++; $display("FAIL reset_idle_ctl: got %b want %b", ctl(), CTL_NORM);
        end
        total++;
        if (stall_cycles !== 16'd0 || flush_events !== 16'd0 || mem_timeout !== 1'b0) begin
            bad++; $display("FAIL reset_stats: got stall=%0d flush=%0d tmo=%b want 0 0 0",
                            stall_cycles, flush_events, mem_timeout);
        end
        tick();
    endtask

    task automatic test_load_use_r();
        logic [7:0] want [3] = '{CTL_STALL, CTL_STALL, CTL_NORM};
        do_reset();
        set_r_hazard();
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (ctl() !== want[i]) begin
                bad++; $display("FAIL lu_r cyc%0d: got %b want %b", i, ctl(), want[i]);
            end
            tick();
            ex_memRead = 0;
        end
        total++;
        if (stall_cycles !== 16'd2) begin
            bad++; $display("FAIL lu_r_stalls: got %0d want 2", stall_cycles);
        end
        idle_inputs();
    endtask

    task automatic test_s_file();
        logic [7:0] want [4] = '{CTL_NORM, CTL_STALL, CTL_STALL, CTL_NORM};
        do_reset();
        id_valid = 1; id_Sn = 3'd5; id_use_Sn = 0;
        ex_memRead = 1; ex_S_regWrite = 1; ex_Sd = 3'd5;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (ctl() !== want[i]) begin
                bad++; $display("FAIL lu_s cyc%0d: got %b want %b", i, ctl(), want[i]);
            end
            tick();
            if (i == 0) id_use_Sn = 1;
            else ex_memRead = 0;
        end
        total++;
        if (stall_cycles !== 16'd2) begin
            bad++; $display("FAIL lu_s_stalls: got %0d want 2", stall_cycles);
        end
        idle_inputs();
    endtask

    task automatic test_branch_abort();
        do_reset();
        set_r_hazard();
        #1;
        total++;
        if (ctl() !== CTL_STALL) begin
            bad++; $display("FAIL br_abort_lu: got %b want %b", ctl(), CTL_STALL);
        end
        tick();
        ex_memRead = 0; mem_branch = 1; mem_taken = 1;
        #1;
        total++;
        if (ctl() !== CTL_BR) begin
            bad++; $display("FAIL br_abort_squash: got %b want %b", ctl(), CTL_BR);
        end
        tick();
        mem_branch = 0; mem_taken = 0;
        #1;
        total++;
        if (ctl() !== CTL_NORM) begin
            bad++; $display("FAIL br_abort_after: got %b want %b", ctl(), CTL_NORM);
        end
        total++;
        if (flush_events !== 16'd1 || stall_cycles !== 16'd1) begin
            bad++; $display("FAIL br_abort_stats: got flush=%0d stall=%0d want 1 1",
                            flush_events, stall_cycles);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_freeze();
        do_reset();
        mem_busy = 1;
        for (int i = 0; i < 20; i++) begin
            #1;
            total++;
            if (ctl() !== CTL_ZERO || mem_timeout !== 1'(i >= MT)) begin
                bad++; $display("FAIL freeze cyc%0d: got ctl=%b tmo=%b want ctl=%b tmo=%b",
                                i, ctl(), mem_timeout, CTL_ZERO, 1'(i >= MT));
            end
            tick();
        end
        mem_busy = 0;
        #1;
        total++;
        if (ctl() !== CTL_NORM || mem_timeout !== 1'b1 || stall_cycles !== 16'd20) begin
            bad++; $display("FAIL freeze_end: got ctl=%b tmo=%b stall=%0d want %b 1 20",
                            ctl(), mem_timeout, stall_cycles, CTL_NORM);
        end
        tick();
        tick();
        total++;
        if (mem_timeout !== 1'b1) begin
            bad++; $display("FAIL tmo_sticky: got %b want 1", mem_timeout);
        end
        do_reset();
        #1;
        total++;
        if (mem_timeout !== 1'b0) begin
            bad++; $display("FAIL tmo_clear: got %b want 0", mem_timeout);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            mem_busy = 1;
            repeat (7) tick();
            mem_busy = 0;
            tick();
        end
        #1;
        total++;
        if (d4_stall_cycles !== 4'd15 || stall_cycles !== 16'd21) begin
            bad++; $display("FAIL stat_sat: got w4=%0d w16=%0d want 15 21",
                            d4_stall_cycles, stall_cycles);
        end
        tick();
    endtask

    task automatic test_stall_freeze();
        logic [7:0] want [6] = '{CTL_STALL, CTL_ZERO, CTL_ZERO, CTL_ZERO, CTL_STALL, CTL_NORM};
        do_reset();
        set_r_hazard();
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if (ctl() !== want[i]) begin
                bad++; $display("FAIL lu_freeze cyc%0d: got %b want %b", i, ctl(), want[i]);
            end
            tick();
            ex_memRead = 0;
            mem_busy = (i < 3);
        end
        total++;
        if (stall_cycles !== 16'd5 || mem_timeout !== 1'b0) begin
            bad++; $display("FAIL lu_freeze_stats: got stall=%0d tmo=%b want 5 0",
                            stall_cycles, mem_timeout);
        end
        idle_inputs();
    endtask

    function automatic bit model_haz();
        bit r_dep, s_dep;
        r_dep = ex_R_regWrite && ((id_use_Rm && id_Rm == ex_Rd) || (id_use_Rn && id_Rn == ex_Rd));
        s_dep = ex_S_regWrite && ((id_use_Sm && id_Sm == ex_Sd) || (id_use_Sn && id_Sn == ex_Sd));
        return id_valid && ex_memRead && (r_dep || s_dep);
    endfunction

    task automatic test_random();
        int burst;
        logic [7:0] exp_ctl;
        bit h, b;
        int e16s, e16f, e4s, e4f;
        do_reset();
        m_stall_left = 0; m_busy_run = 0; m_stalls = 0; m_flushes = 0; m_tmo = 0;
        burst = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) != 0);
            id_valid = ($urandom_range(0, 3) != 0);
            id_Rm = 3'($urandom_range(0, 3)); id_Rn = 3'($urandom_range(0, 3));
            id_Sm = 3'($urandom_range(0, 3)); id_Sn = 3'($urandom_range(0, 3));
            id_use_Rm = 1'($urandom); id_use_Rn = 1'($urandom);
            id_use_Sm = 1'($urandom); id_use_Sn = 1'($urandom);
            ex_memRead = 1'($urandom);
            ex_R_regWrite = 1'($urandom); ex_S_regWrite = 1'($urandom);
            ex_Rd = 3'($urandom_range(0, 3)); ex_Sd = 3'($urandom_range(0, 3));
            mem_branch = ($urandom_range(0, 5) == 0);
            mem_taken = 1'($urandom);
            if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(1, 20);
            mem_busy = (burst > 0);
            if (burst > 0) burst--;
            #1;
            h = model_haz();
            b = mem_branch && mem_taken;
            if (!reset || mem_busy) exp_ctl = CTL_ZERO;
            else if (b) exp_ctl = CTL_BR;
            else if (m_stall_left > 0 || h) exp_ctl = CTL_STALL;
            else exp_ctl = CTL_NORM;
            e16s = (m_stalls > 65535) ? 65535 : m_stalls;
            e16f = (m_flushes > 65535) ? 65535 : m_flushes;
            e4s = (m_stalls > 15) ? 15 : m_stalls;
            e4f = (m_flushes > 15) ? 15 : m_flushes;
            total++;
            if (ctl() !== exp_ctl || ctl4() !== exp_ctl) begin
                bad++; $display("FAIL rnd_ctl cyc%0d: got %b/%b want %b", c, ctl(), ctl4(), exp_ctl);
            end
            total++;
            if (stall_cycles !== 16'(e16s) || d4_stall_cycles !== 4'(e4s)) begin
                bad++; $display("FAIL rnd_stalls cyc%0d: got %0d/%0d want %0d/%0d",
                                c, stall_cycles, d4_stall_cycles, e16s, e4s);
            end
            total++;
            if (flush_events !== 16'(e16f) || d4_flush_events !== 4'(e4f)) begin
                bad++; $display("FAIL rnd_flushes cyc%0d: got %0d/%0d want %0d/%0d",
                                c, flush_events, d4_flush_events, e16f, e4f);
            end
            total++;
            if (mem_timeout !== m_tmo || d4_mem_timeout !== m_tmo) begin
                bad++; $display("FAIL rnd_tmo cyc%0d: got %b/%b want %b",
                                c, mem_timeout, d4_mem_timeout, m_tmo);
            end
            if (!reset) begin
                m_stall_left = 0; m_busy_run = 0; m_stalls = 0; m_flushes = 0; m_tmo = 0;
            end else if (mem_busy) begin
                m_busy_run++;
                m_stalls++;
                if (m_busy_run >= MT) m_tmo = 1;
            end else begin
                m_busy_run = 0;
                if (b) begin
                    m_flushes++;
                    m_stall_left = 0;
                end else if (m_stall_left > 0) begin
                    m_stall_left--;
                    m_stalls++;
                end else if (h) begin
                    m_stalls++;
                    m_stall_left = LSC - 1;
                end
            end
            tick();
        end
        reset = 1;
        idle_inputs();
    endtask

    initial begin
        reset = 0;
        idle_inputs();
        tick();
        test_reset();
        test_load_use_r();
        test_s_file();
        test_branch_abort();
        test_freeze();
        test_saturation();
        test_stall_freeze();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
